// File: rtl/control_unit_pkg.sv
// Shared encodings for the bus-datapath control unit: opcodes, FSM states, ALU ops, IR field layout.
// CONTROL_UNIT_AND_OP_EN enables the optional AND instruction (opcode 100).
package control_unit_pkg;

   localparam int unsigned DATA_WIDTH    = 16;
   localparam int unsigned IMM_WIDTH     = 7;
   localparam int unsigned NUM_REGS      = 8;
   localparam int unsigned OP_WIDTH      = 3;
   localparam int unsigned REG_IDX_WIDTH = 3;
   localparam int unsigned ALU_OP_WIDTH  = 2;

   // IR layout: [15:13] opcode, [12:10] rx, [9:7] ry, [6:0] imm
   localparam int unsigned IR_OP_LSB  = 13;
   localparam int unsigned IR_RX_LSB  = 10;
   localparam int unsigned IR_RY_LSB  = 7;
   localparam int unsigned IR_IMM_LSB = 0;

   localparam logic [OP_WIDTH-1:0] OP_MV  = 3'b000;
   localparam logic [OP_WIDTH-1:0] OP_MVI = 3'b001;
   localparam logic [OP_WIDTH-1:0] OP_ADD = 3'b010;
   localparam logic [OP_WIDTH-1:0] OP_SUB = 3'b011;
   localparam logic [OP_WIDTH-1:0] OP_AND = 3'b100;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 2'b00;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 2'b01;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 2'b10;

`ifdef CONTROL_UNIT_AND_OP_EN
   localparam bit AND_OP_EN = 1'b1;
`else
   localparam bit AND_OP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_T1   = 2'b01,
      S_T2   = 2'b10,
      S_T3   = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      CLS_MV  = 2'b00,
      CLS_MVI = 2'b01,
      CLS_ALU = 2'b10,
      CLS_ILL = 2'b11
   } instr_class_t;

   // Groups opcodes by the micro-sequence they follow
   function automatic instr_class_t decode_class(input logic [OP_WIDTH-1:0] op);
      instr_class_t cls;
      case (op)
         OP_MV:          cls = CLS_MV;
         OP_MVI:         cls = CLS_MVI;
         OP_ADD, OP_SUB: cls = CLS_ALU;
         OP_AND:         cls = AND_OP_EN ? CLS_ALU : CLS_ILL;
         default:        cls = CLS_ILL;
      endcase
      return cls;
   endfunction

   function automatic logic [ALU_OP_WIDTH-1:0] alu_op_for(input logic [OP_WIDTH-1:0] op);
      logic [ALU_OP_WIDTH-1:0] res;
      res = ALU_ADD;
      if (op == OP_SUB) res = ALU_SUB;
      if (op == OP_AND && AND_OP_EN) res = ALU_AND;
      return res;
   endfunction

endpackage

// File: rtl/control_unit_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable; all zeros when disabled.
module dec3to8
   import control_unit_pkg::*;
(
   input  logic [REG_IDX_WIDTH-1:0] i_idx,
   input  logic                     i_en,
   output logic [NUM_REGS-1:0]      o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot[i_idx] = 1'b1;
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencing FSM for the 16-bit bus datapath: run/done handshake, Moore-decoded selects/enables.
// CONTROL_UNIT_AND_OP_EN enables opcode 100 (AND); otherwise it takes the illegal path.
module control_unit
   import control_unit_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    run,
   input  logic [DATA_WIDTH-1:0]   ir_in,
   output logic [DATA_WIDTH-1:0]   imediate,
   output logic                    imediate_select,
   output logic [NUM_REGS-1:0]     r_sel,
   output logic                    r_select,
   output logic [NUM_REGS-1:0]     r_in,
   output logic                    a_in,
   output logic                    g_in,
   output logic [ALU_OP_WIDTH-1:0] alu_op,
   output logic                    done,
   output logic                    busy,
   output logic                    illegal
);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [DATA_WIDTH-1:0]   r_ir;
   logic                    w_ir_load;

   logic [OP_WIDTH-1:0]      w_op;
   logic [REG_IDX_WIDTH-1:0] w_rx;
   logic [REG_IDX_WIDTH-1:0] w_ry;
   instr_class_t             w_class;

   logic                     w_rsel_en;
   logic [REG_IDX_WIDTH-1:0] w_rsel_idx;
   logic                     w_rin_en;
   logic [REG_IDX_WIDTH-1:0] w_rin_idx;

   assign w_op      = r_ir[IR_OP_LSB +: OP_WIDTH];
   assign w_rx      = r_ir[IR_RX_LSB +: REG_IDX_WIDTH];
   assign w_ry      = r_ir[IR_RY_LSB +: REG_IDX_WIDTH];
   assign w_class   = decode_class(w_op);
   assign w_ir_load = (r_state == S_IDLE) && run;

   // State and instruction register; IR only loads when a run is accepted in IDLE
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ir    <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_ir_load) r_ir <= ir_in;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (run) w_next_state = S_T1;
         S_T1:    w_next_state = (w_class == CLS_ALU) ? S_T2 : S_IDLE;
         S_T2:    w_next_state = S_T3;
         S_T3:    w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Moore output decode from state and IR
   always_comb begin
      imediate        = DATA_WIDTH'(r_ir[IR_IMM_LSB +: IMM_WIDTH]);
      imediate_select = 1'b0;
      r_select        = 1'b0;
      a_in            = 1'b0;
      g_in            = 1'b0;
      alu_op          = ALU_ADD;
      done            = 1'b0;
      illegal         = 1'b0;
      busy            = (r_state != S_IDLE);
      w_rsel_en       = 1'b0;
      w_rsel_idx      = '0;
      w_rin_en        = 1'b0;
      w_rin_idx       = '0;
      case (r_state)
         S_T1: begin
            case (w_class)
               CLS_MV: begin
                  w_rsel_en  = 1'b1;
                  w_rsel_idx = w_ry;
                  w_rin_en   = 1'b1;
                  w_rin_idx  = w_rx;
                  done       = 1'b1;
               end
               CLS_MVI: begin
                  imediate_select = 1'b1;
                  w_rin_en        = 1'b1;
                  w_rin_idx       = w_rx;
                  done            = 1'b1;
               end
               CLS_ALU: begin
                  w_rsel_en  = 1'b1;
                  w_rsel_idx = w_rx;
                  a_in       = 1'b1;
               end
               default: begin
                  done    = 1'b1;
                  illegal = 1'b1;
               end
            endcase
         end
         S_T2: begin
            w_rsel_en  = 1'b1;
            w_rsel_idx = w_ry;
            g_in       = 1'b1;
            alu_op     = alu_op_for(w_op);
         end
         S_T3: begin
            r_select  = 1'b1;
            w_rin_en  = 1'b1;
            w_rin_idx = w_rx;
            done      = 1'b1;
         end
         default: ;
      endcase
   end

   dec3to8 u_dec_rsel (
      .i_idx    (w_rsel_idx),
      .i_en     (w_rsel_en),
      .o_onehot (r_sel)
   );

   dec3to8 u_dec_rin (
      .i_idx    (w_rin_idx),
      .i_en     (w_rin_en),
      .o_onehot (r_in)
   );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed plan items plus random instructions against a per-instruction schedule model.
module tb_control_unit;

   typedef struct packed {
      logic [15:0] imm;
      logic        isel;
      logic [7:0]  rsel;
      logic        rselect;
      logic [7:0]  rin;
      logic        ain;
      logic        gin;
      logic [1:0]  aluop;
      logic        done;
      logic        busy;
      logic        illegal;
   } obs_t;

   logic        clock;
   logic        reset;
   logic        run;
   logic [15:0] ir_in;
   logic [15:0] imediate;
   logic        imediate_select;
   logic [7:0]  r_sel;
   logic        r_select;
   logic [7:0]  r_in;
   logic        a_in;
   logic        g_in;
   logic [1:0]  alu_op;
   logic        done;
   logic        busy;
   logic        illegal;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] last_ir;
   obs_t        exp_q[$];

`ifdef CONTROL_UNIT_AND_OP_EN
   localparam bit AND_EN = 1'b1;
`else
   localparam bit AND_EN = 1'b0;
`endif

   control_unit dut (
      .clock           (clock),
      .reset           (reset),
      .run             (run),
      .ir_in           (ir_in),
      .imediate        (imediate),
      .imediate_select (imediate_select),
      .r_sel           (r_sel),
      .r_select        (r_select),
      .r_in            (r_in),
      .a_in            (a_in),
      .g_in            (g_in),
      .alu_op          (alu_op),
      .done            (done),
      .busy            (busy),
      .illegal         (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic obs_t observed();
      obs_t o;
      o = '{imediate, imediate_select, r_sel, r_select, r_in, a_in, g_in, alu_op, done, busy, illegal};
      return o;
   endfunction

   function automatic obs_t idle_exp(input logic [15:0] ir);
      obs_t e;
      e     = '0;
      e.imm = {9'b0, ir[6:0]};
      return e;
   endfunction

   // Cycle-by-cycle schedule of one instruction, from accept+1 up to and including done
   function automatic void build_schedule(input logic [15:0] ir);
      int          op;
      int          rx;
      int          ry;
      obs_t        base;
      obs_t        t;
      op = int'(ir[15:13]);
      rx = int'(ir[12:10]);
      ry = int'(ir[9:7]);
      base      = idle_exp(ir);
      base.busy = 1'b1;
      exp_q.delete();
      if (op == 0) begin
         t = base; t.rsel = 8'b1 << ry; t.rin = 8'b1 << rx; t.done = 1'b1; exp_q.push_back(t);
      end else if (op == 1) begin
         t = base; t.isel = 1'b1; t.rin = 8'b1 << rx; t.done = 1'b1; exp_q.push_back(t);
      end else if (op == 2 || op == 3 || (op == 4 && AND_EN)) begin
         t = base; t.rsel = 8'b1 << rx; t.ain = 1'b1; exp_q.push_back(t);
         t = base; t.rsel = 8'b1 << ry; t.gin = 1'b1;
         t.aluop = (op == 2) ? 2'd0 : (op == 3) ? 2'd1 : 2'd2;
         exp_q.push_back(t);
         t = base; t.rselect = 1'b1; t.rin = 8'b1 << rx; t.done = 1'b1; exp_q.push_back(t);
      end else begin
         t = base; t.done = 1'b1; t.illegal = 1'b1; exp_q.push_back(t);
      end
   endfunction

   task automatic check(input string tag, input obs_t e);
      obs_t o;
      o = observed();
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Called #1 after an edge with the DUT in IDLE; runs one instruction and ends in the following IDLE cycle
   task automatic run_instr(input string tag, input logic [15:0] ir, input bit hold, input logic [15:0] nxt);
      check({tag, "_idle_pre"}, idle_exp(last_ir));
      run   = 1'b1;
      ir_in = ir;
      build_schedule(ir);
      for (int i = 0; i < exp_q.size(); i++) begin
         tick();
         check($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
         if (i == exp_q.size() - 1) begin
            run   = hold;
            ir_in = nxt;
         end else begin
            run   = hold ? 1'b1 : 1'($urandom);
            ir_in = 16'($urandom);
         end
      end
      last_ir = ir;
      tick();
      check({tag, "_idle_post"}, idle_exp(last_ir));
   endtask

   initial begin
      obs_t        e;
      logic [15:0] ir;
      reset   = 1'b1;
      run     = 1'b0;
      ir_in   = 16'hFFFF;
      last_ir = 16'h0000;

      tick();
      check("reset_hold1", idle_exp(16'h0000));
      tick();
      check("reset_hold2", idle_exp(16'h0000));
      reset = 1'b0;
      tick();
      check("after_reset_run0", idle_exp(16'h0000));

      run_instr("mvi_r2_5", 16'h2805, 1'b0, 16'h0000);
      run_instr("add_r1_r6", 16'h4700, 1'b0, 16'h0000);
      // run held high across sub; mv r3,r3 only accepted in the IDLE cycle after done
      run_instr("sub_r3_r5_held", 16'h6E80, 1'b1, 16'h0D80);
      run_instr("mv_r3_r3", 16'h0D80, 1'b0, 16'h0000);
      run_instr("illegal_111", 16'hE000, 1'b0, 16'h0000);
      run_instr("op100_r4_r2", 16'h9100, 1'b0, 16'h0000);

      // reset during T2 of add r5,r1
      ir = 16'h5480;
      check("rst_mid_idle_pre", idle_exp(last_ir));
      run   = 1'b1;
      ir_in = ir;
      build_schedule(ir);
      tick();
      check("rst_mid_t1", exp_q[0]);
      run = 1'b0;
      tick();
      check("rst_mid_t2", exp_q[1]);
      reset = 1'b1;
      #1;
      check("rst_mid_t2_during_reset", exp_q[1]);
      tick();
      check("rst_mid_idle_after", idle_exp(16'h0000));
      reset   = 1'b0;
      last_ir = 16'h0000;
      tick();
      e = idle_exp(16'h0000);
      check("rst_mid_no_done", e);
      run_instr("post_rst_add", 16'h4700, 1'b0, 16'h0000);

      for (int n = 0; n < 40; n++) begin
         ir = 16'($urandom);
         run_instr($sformatf("rand%0d_%h", n, ir), ir, 1'b0, 16'h0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Sequencing FSM for the 16-bit bus datapath.
- Latches an instruction word and decodes it.
- Drives the one-hot source selects consumed by the bus multiplexer, plus the destination load enables (register, A, G) that capture the bus value.
- Multi-cycle, one instruction at a time; handshake is run/done.

Parameters:
- DATA_WIDTH, 16, instruction and bus width
- IMM_WIDTH, 7, immediate field width, zero-extended onto imediate
- NUM_REGS, 8, general registers r0..r7 (select/enable vector width)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  start request; sampled only in IDLE
- ir_in  in  16  instruction word, captured when run accepted
- imediate  out  16  zero-extended IR[6:0]
- imediate_select  out  1  bus source = immediate
- r_sel  out  8  one-hot bus source r0..r7 (bit n -> rn_select)
- r_select  out  1  bus source = G (ALU result)
- r_in  out  8  one-hot register load enable
- a_in  out  1  load A from bus
- g_in  out  1  load G from ALU
- alu_op  out  2  00 add, 01 sub, 10 and
- done  out  1  one-cycle pulse on final cycle of an instruction
- busy  out  1  high in any state except IDLE
- illegal  out  1  one-cycle pulse with done for an undefined opcode

Behaviour:
- IR format: [15:13] opcode, [12:10] rx, [9:7] ry, [6:0] imm.
- Opcodes: 000 mv rx<-ry; 001 mvi rx<-imm; 010 add rx<-rx+ry; 011 sub rx<-rx-ry; 100 and (optional feature); others illegal.
- States: IDLE, T1, T2, T3; 2-bit state register; IR is 16-bit.
- Outputs decode combinationally from state and IR (Moore); no registered outputs other than state and IR.
- Reset: state=IDLE, IR=0. All outputs 0 while in IDLE, except imediate, which reflects IR.
- IDLE: run=1 -> IR<=ir_in, go to T1. run=0 -> stay.
- T1:
  - mv: r_sel[ry], r_in[rx], done -> IDLE.
  - mvi: imediate_select, r_in[rx], done -> IDLE.
  - add/sub/and: r_sel[rx], a_in -> T2.
  - illegal: done, illegal, no enables -> IDLE.
- T2: r_sel[ry], g_in, alu_op per opcode -> T3.
- T3: r_select, r_in[rx], done -> IDLE.
- Latency, run accept to done: mv/mvi/illegal 1 cycle (done in T1); ALU ops 3 cycles.
- Minimum run spacing: done cycle, then one IDLE cycle.
- Invariant: at most one of {imediate_select, r_select, r_sel bits} high in any cycle; at most one r_in bit high.
- rx==ry is legal; mv r3,r3 asserts r_sel[3] and r_in[3] together.
- run while busy: ignored; ir_in not sampled.
- reset mid-instruction: next state IDLE, IR=0. Current-cycle outputs still follow the pre-reset state; no enables from the following cycle on.
- ir_in changing after acceptance: no effect.

Optional Feature:
- Macro: CONTROL_UNIT_AND_OP_EN.
- Defined: opcode 100 runs the ALU sequence with alu_op=10.
- Undefined: opcode 100 takes the illegal path (T1 done+illegal, no enables); alu_op never drives 10.

Decomposition:
- Package control_unit_pkg:
  - opcode localparams (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND)
  - state encoding (S_IDLE, S_T1, S_T2, S_T3)
  - ALU_ADD / ALU_SUB / ALU_AND encodings
  - IR field bit positions
- Sub-module: dec3to8 (3-bit index + enable -> 8-bit one-hot); two instances, one for r_sel and one for r_in.

Test Plan:
- Reset held 2 cycles, then released, run=0 -> busy=0, done=0, r_sel=0, r_in=0, all selects 0.
- mvi r2,#5 (ir_in=16'h2805), run one cycle -> next cycle imediate=16'h0005, imediate_select=1, r_in=8'h04, done=1; following cycle busy=0.
- add r1,r6 (16'h4700) -> T1: r_sel=8'h02, a_in=1; T2: r_sel=8'h40, g_in=1, alu_op=00; T3: r_select=1, r_in=8'h02, done=1.
- sub with run held high and ir_in changed mid-sequence -> IR unchanged, alu_op=01 in T2, second instruction accepted only after the IDLE cycle following done.
- Opcode 111 (16'hE000) -> single cycle done=1, illegal=1, r_in=0. Opcode 100: illegal without CONTROL_UNIT_AND_OP_EN; alu_op=10 sequence with it.
- reset asserted during T2 of add -> next cycle IDLE, g_in=0, r_in=0, done never pulses; new run accepted afterwards.
